// File: rtl/reg_file_rename.sv
// ============================================================================
// reg_file_rename : architectural register file with rename/dependence table
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_rename #(
   parameter int ROB_WIDTH = 3,
   parameter int NREG      = 32
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   input  logic                 dec_ready,
   input  logic [4:0]           rs1,
   input  logic [4:0]           rs2,
   input  logic [4:0]           rd,
   input  logic [ROB_WIDTH-1:0] empty_rob_id,
   output logic [31:0]          val1,
   output logic                 has_dep1,
   output logic [ROB_WIDTH-1:0] dep1,
   output logic [31:0]          val2,
   output logic                 has_dep2,
   output logic [ROB_WIDTH-1:0] dep2,
   output logic [ROB_WIDTH-1:0] search_rob_id_1,
   input  logic                 search_ready_1,
   input  logic [31:0]          search_val_1,
   output logic [ROB_WIDTH-1:0] search_rob_id_2,
   input  logic                 search_ready_2,
   input  logic [31:0]          search_val_2,
   input  logic                 commit_en,
   input  logic [ROB_WIDTH-1:0] commit_rob_id,
   input  logic [4:0]           commit_reg_id,
   input  logic [31:0]          commit_val
);

   logic [31:0]          r_value [0:NREG-1];
   logic                 r_busy  [0:NREG-1];
   logic [ROB_WIDTH-1:0] r_tag   [0:NREG-1];

   logic [32:0]          w_lk1;
   logic [32:0]          w_lk2;

   // Returns {has_dep, value}; the pre-rename mapping is used so rs==rd sees the old producer.
   function automatic logic [32:0] f_lookup(input logic [4:0]  rs,
                                            input logic        sready,
                                            input logic [31:0] sval);
      if (rs == 5'd0)
         f_lookup = {1'b0, 32'd0};
      else if (!r_busy[rs])
         f_lookup = {1'b0, r_value[rs]};
      else if (commit_en && (commit_rob_id == r_tag[rs]))
         f_lookup = {1'b0, commit_val};
      else if (sready)
         f_lookup = {1'b0, sval};
      else
         f_lookup = {1'b1, 32'd0};
   endfunction

   assign w_lk1 = f_lookup(rs1, search_ready_1, search_val_1);
   assign w_lk2 = f_lookup(rs2, search_ready_2, search_val_2);

   assign has_dep1        = w_lk1[32];
   assign val1            = w_lk1[31:0];
   assign dep1            = r_tag[rs1];
   assign search_rob_id_1 = r_tag[rs1];

   assign has_dep2        = w_lk2[32];
   assign val2            = w_lk2[31:0];
   assign dep2            = r_tag[rs2];
   assign search_rob_id_2 = r_tag[rs2];

   // Statement order encodes priority: rename and flush override the commit busy-clear.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < NREG; i++) begin
            r_value[i] <= 32'd0;
            r_busy[i]  <= 1'b0;
            r_tag[i]   <= '0;
         end
      end else if (rdy_in) begin
         if (commit_en && (commit_reg_id != 5'd0)) begin
            r_value[commit_reg_id] <= commit_val;
            if (r_busy[commit_reg_id] && (r_tag[commit_reg_id] == commit_rob_id))
               r_busy[commit_reg_id] <= 1'b0;
         end
         if (clear) begin
            for (int i = 0; i < NREG; i++)
               r_busy[i] <= 1'b0;
         end else if (dec_ready && (rd != 5'd0)) begin
            r_tag[rd]  <= empty_rob_id;
            r_busy[rd] <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_rename.sv
// ============================================================================
// tb_reg_file_rename : directed vector table plus randomized model comparison
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_rename;

   localparam int RW = 3;

   logic          clk_in = 1'b0;
   logic          rst_in, rdy_in, clear, dec_ready;
   logic [4:0]    rs1, rs2, rd;
   logic [RW-1:0] empty_rob_id;
   logic [31:0]   val1, val2;
   logic          has_dep1, has_dep2;
   logic [RW-1:0] dep1, dep2, search_rob_id_1, search_rob_id_2;
   logic          search_ready_1, search_ready_2;
   logic [31:0]   search_val_1, search_val_2;
   logic          commit_en;
   logic [RW-1:0] commit_rob_id;
   logic [4:0]    commit_reg_id;
   logic [31:0]   commit_val;

   int n_chk  = 0;
   int n_fail = 0;

   reg_file_rename #(.ROB_WIDTH(RW), .NREG(32)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .dec_ready(dec_ready), .rs1(rs1), .rs2(rs2), .rd(rd), .empty_rob_id(empty_rob_id),
      .val1(val1), .has_dep1(has_dep1), .dep1(dep1),
      .val2(val2), .has_dep2(has_dep2), .dep2(dep2),
      .search_rob_id_1(search_rob_id_1), .search_ready_1(search_ready_1), .search_val_1(search_val_1),
      .search_rob_id_2(search_rob_id_2), .search_ready_2(search_ready_2), .search_val_2(search_val_2),
      .commit_en(commit_en), .commit_rob_id(commit_rob_id), .commit_reg_id(commit_reg_id),
      .commit_val(commit_val)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic          dec;
      logic [4:0]    rs1, rs2, rd;
      logic [RW-1:0] eid;
      logic          sr1;
      logic [31:0]   sv1;
      logic          sr2;
      logic [31:0]   sv2;
      logic          cen;
      logic [RW-1:0] crob;
      logic [4:0]    creg;
      logic [31:0]   cval;
      logic          clr;
      logic          stall;
      logic [31:0]   ev1;
      logic          eh1;
      logic [RW-1:0] et1;
      logic [31:0]   ev2;
      logic          eh2;
      logic [RW-1:0] et2;
   } vec_t;

   vec_t vecs [20];

   // Reference state: what each architectural register holds / waits on
   logic [31:0]   m_val  [32];
   logic          m_busy [32];
   logic [RW-1:0] m_tag  [32];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      dec_ready = v.dec; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; empty_rob_id = v.eid;
      search_ready_1 = v.sr1; search_val_1 = v.sv1;
      search_ready_2 = v.sr2; search_val_2 = v.sv2;
      commit_en = v.cen; commit_rob_id = v.crob; commit_reg_id = v.creg; commit_val = v.cval;
      clear = v.clr; rdy_in = !v.stall;
   endtask

   task automatic check_ports(input string tag, input logic [31:0] ev1, input logic eh1,
                              input logic [RW-1:0] et1, input logic [31:0] ev2,
                              input logic eh2, input logic [RW-1:0] et2);
      chk({tag, ".val1"}, val1, ev1);
      chk({tag, ".has_dep1"}, {31'd0, has_dep1}, {31'd0, eh1});
      chk({tag, ".sid1"}, {29'd0, search_rob_id_1}, {29'd0, et1});
      if (eh1) chk({tag, ".dep1"}, {29'd0, dep1}, {29'd0, et1});
      chk({tag, ".val2"}, val2, ev2);
      chk({tag, ".has_dep2"}, {31'd0, has_dep2}, {31'd0, eh2});
      chk({tag, ".sid2"}, {29'd0, search_rob_id_2}, {29'd0, et2});
      if (eh2) chk({tag, ".dep2"}, {29'd0, dep2}, {29'd0, et2});
   endtask

   task automatic model_lookup(input logic [4:0] rs, input logic sr, input logic [31:0] sv,
                               output logic [31:0] v, output logic h, output logic [RW-1:0] t);
      t = m_tag[rs];
      h = 1'b0;
      v = 32'd0;
      if (rs == 5'd0)                                  v = 32'd0;
      else if (!m_busy[rs])                            v = m_val[rs];
      else if (commit_en && commit_rob_id == m_tag[rs]) v = commit_val;
      else if (sr)                                     v = sv;
      else                                             h = 1'b1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_val[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
   endtask

   // A register's newest producer is the last accepted rename; a flush forgets all producers.
   task automatic model_step();
      logic          ren_hit;
      ren_hit = dec_ready && !clear && rd != 5'd0;
      if (!rdy_in) return;
      if (commit_en && commit_reg_id != 5'd0) begin
         m_val[commit_reg_id] = commit_val;
         if (m_busy[commit_reg_id] && m_tag[commit_reg_id] == commit_rob_id &&
             !(ren_hit && rd == commit_reg_id))
            m_busy[commit_reg_id] = 1'b0;
      end
      if (clear)
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      if (ren_hit) begin
         m_busy[rd] = 1'b1;
         m_tag[rd]  = empty_rob_id;
      end
   endtask

   initial begin
      vec_t          v;
      logic [31:0]   ev1, ev2;
      logic          eh1, eh2;
      logic [RW-1:0] et1, et2;

      // Directed sequence; expectations are hand-derived and state carries across rows.
      vecs[0]  = '{default:'0, dec:1'b1, rs1:5'd5};
      vecs[1]  = '{default:'0, dec:1'b1, rd:5'd3, eid:3'd2};
      vecs[2]  = '{default:'0, rs1:5'd3, eh1:1'b1, et1:3'd2};
      vecs[3]  = '{default:'0, rs1:5'd3, sr1:1'b1, sv1:32'h55, ev1:32'h55, et1:3'd2};
      vecs[4]  = '{default:'0, dec:1'b1, rs1:5'd3, cen:1'b1, crob:3'd2, creg:5'd3, cval:32'h1234,
                   ev1:32'h1234, et1:3'd2};
      vecs[5]  = '{default:'0, rs1:5'd3, ev1:32'h1234, et1:3'd2};
      vecs[6]  = '{default:'0, dec:1'b1, rd:5'd4, eid:3'd1};
      vecs[7]  = '{default:'0, dec:1'b1, rd:5'd4, eid:3'd6, rs1:5'd4, cen:1'b1, crob:3'd1,
                   creg:5'd4, cval:32'hAAAA, ev1:32'hAAAA, et1:3'd1};
      vecs[8]  = '{default:'0, rs1:5'd4, eh1:1'b1, et1:3'd6};
      vecs[9]  = '{default:'0, rs1:5'd4, cen:1'b1, crob:3'd1, creg:5'd4, cval:32'hBBBB,
                   eh1:1'b1, et1:3'd6};
      vecs[10] = '{default:'0, rs1:5'd4, rs2:5'd4, sr2:1'b1, sv2:32'h77, eh1:1'b1, et1:3'd6,
                   ev2:32'h77, et2:3'd6};
      vecs[11] = '{default:'0, dec:1'b1, rd:5'd7, eid:3'd3};
      vecs[12] = '{default:'0, dec:1'b1, rd:5'd9, eid:3'd4, rs1:5'd7, eh1:1'b1, et1:3'd3};
      vecs[13] = '{default:'0, dec:1'b1, rd:5'd10, eid:3'd5, clr:1'b1, rs1:5'd9, rs2:5'd7,
                   eh1:1'b1, et1:3'd4, eh2:1'b1, et2:3'd3};
      vecs[14] = '{default:'0, rs1:5'd7, rs2:5'd9, et1:3'd3, et2:3'd4};
      vecs[15] = '{default:'0, rs1:5'd10, rs2:5'd4, ev2:32'hBBBB, et2:3'd6};
      vecs[16] = '{default:'0, cen:1'b1, creg:5'd0, cval:32'hFFFF};
      vecs[17] = '{default:'0, rs1:5'd0};
      vecs[18] = '{default:'0, stall:1'b1, dec:1'b1, rd:5'd8, eid:3'd7};
      vecs[19] = '{default:'0, rs1:5'd8};

      rst_in = 1'b1;
      drive('0);
      rdy_in = 1'b1;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk_in);
         drive(vecs[i]);
         #1;
         check_ports($sformatf("vec%0d", i), vecs[i].ev1, vecs[i].eh1, vecs[i].et1,
                     vecs[i].ev2, vecs[i].eh2, vecs[i].et2);
      end

      // Reset must apply even while rdy_in is low: x3 and x4 hold nonzero values here.
      @(negedge clk_in);
      drive('{default:'0, stall:1'b1});
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      drive('{default:'0, rs1:5'd3, rs2:5'd4});
      #1;
      check_ports("rst_rdy0", 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);

      model_reset();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk_in);
         v = '0;
         v.dec   = ($urandom_range(0, 9) < 6);
         v.rs1   = 5'($urandom_range(0, 31));
         v.rs2   = ($urandom_range(0, 3) == 0) ? v.rs1 : 5'($urandom_range(0, 31));
         v.rd    = ($urandom_range(0, 3) == 0) ? v.rs1 : 5'($urandom_range(0, 31));
         v.eid   = RW'($urandom);
         v.sr1   = ($urandom_range(0, 3) == 0);
         v.sv1   = $urandom;
         v.sr2   = ($urandom_range(0, 3) == 0);
         v.sv2   = $urandom;
         v.cen   = ($urandom_range(0, 9) < 4);
         v.creg  = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
         v.crob  = ($urandom_range(0, 1) == 0) ? m_tag[v.creg] : RW'($urandom);
         v.cval  = $urandom;
         v.clr   = ($urandom_range(0, 19) == 0);
         v.stall = ($urandom_range(0, 9) == 0);
         drive(v);
         #1;
         model_lookup(rs1, search_ready_1, search_val_1, ev1, eh1, et1);
         model_lookup(rs2, search_ready_2, search_val_2, ev2, eh2, et2);
         check_ports($sformatf("rnd%0d", c), ev1, eh1, et1, ev2, eh2, et2);
         model_step();
      end

      @(negedge clk_in);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
